pipe_accum_core: RTL and testbench

PIPE_ACCUM_CORE -- requirements
Module: pipe_accum_core

---
 rtl/pipe_accum_core.sv | 185 ++++++++++++++++++
 tb/tb_pipe_accum_core.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_accum_core.sv
// rtl/pipe_accum_core.sv - 3-stage (IF/EX/WB) accumulator core with program-load and debug ports.
// Define PIPE_FWD_EN for WB->EX forwarding; otherwise EX stalls one cycle on a WB hazard.
module pipe_accum_core #(
  parameter int DW       = 8,
  parameter int NREG     = 8,
  parameter int DM_DEPTH = 128,
  parameter int IM_DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic                        imem_we,
  input  logic [$clog2(IM_DEPTH)-1:0] imem_addr,
  input  logic [DW+3:0]               imem_wdata,
  input  logic [DW-1:0]               dbg_sel,
  output logic [DW-1:0]               dbg_reg,
  output logic [DW-1:0]               dbg_dm,
  output logic [$clog2(IM_DEPTH)-1:0] pc,
  output logic [DW-1:0]               acc,
  output logic                        cy,
  output logic                        z,
  output logic                        halted
);
  localparam int IW = DW + 4;
  localparam int PW = $clog2(IM_DEPTH);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int MW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;
  localparam logic [IW-1:0] NOP = '0;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_MVI = 4'h1, OP_MOVAR = 4'h2, OP_MOVRA = 4'h3,
    OP_ADD = 4'h4, OP_SUB = 4'h5, OP_ANA = 4'h6, OP_XRA = 4'h7,
    OP_LDA = 4'h8, OP_STA = 4'h9, OP_INR = 4'hA, OP_JMP = 4'hB,
    OP_JZ  = 4'hC, OP_JC  = 4'hD, OP_ADI = 4'hE, OP_HLT = 4'hF
  } op_e;

  logic [IW-1:0] imem [IM_DEPTH];
  logic [DW-1:0] rf   [NREG];
  logic [DW-1:0] dm   [DM_DEPTH];

  logic [IW-1:0] if_ir;
  logic          wb_rf_we, wb_dm_we;
  logic [RW-1:0] wb_ridx;
  logic [MW-1:0] wb_midx;
  logic [DW-1:0] wb_data;

  op_e           op;
  logic [DW-1:0] f;
  logic [31:0]   f32, sel32;
  logic [RW-1:0] ridx;
  logic [MW-1:0] midx;
  logic [PW-1:0] jtgt;
  logic          match_r, match_m, stall;
  logic [DW-1:0] opnd_r, opnd_m;

  assign op      = op_e'(if_ir[IW-1 -: 4]);
  assign f       = if_ir[DW-1:0];
  assign f32     = 32'(f);
  assign sel32   = 32'(dbg_sel);
  assign ridx    = RW'(f32 % NREG);
  assign midx    = MW'(f32 % DM_DEPTH);
  assign jtgt    = PW'(f32 % IM_DEPTH);
  assign match_r = wb_rf_we && (wb_ridx == ridx);
  assign match_m = wb_dm_we && (wb_midx == midx);
  assign dbg_reg = rf[RW'(sel32 % NREG)];
  assign dbg_dm  = dm[MW'(sel32 % DM_DEPTH)];

`ifdef PIPE_FWD_EN
  assign opnd_r = match_r ? wb_data : rf[ridx];
  assign opnd_m = match_m ? wb_data : dm[midx];
  assign stall  = 1'b0;
`else
  logic reads_r, reads_m;
  assign opnd_r  = rf[ridx];
  assign opnd_m  = dm[midx];
  assign reads_r = op inside {OP_MOVAR, OP_ADD, OP_SUB, OP_ANA, OP_XRA};
  assign reads_m = (op == OP_LDA);
  // The hazarded instruction stays in IF/EX and re-executes once WB has committed.
  assign stall   = (reads_r && match_r) || (reads_m && match_m);
`endif

  logic [DW-1:0] n_acc;
  logic          n_cy, n_z, n_rf_we, n_dm_we, take, hlt;
  logic [DW:0]   ext;

  always_comb begin
    n_acc   = acc;
    n_cy    = cy;
    n_z     = z;
    n_rf_we = 1'b0;
    n_dm_we = 1'b0;
    take    = 1'b0;
    hlt     = 1'b0;
    ext     = '0;
    case (op)
      OP_MVI:   n_acc = f;
      OP_MOVAR: n_acc = opnd_r;
      OP_MOVRA: n_rf_we = 1'b1;
      OP_ADD: begin
        ext   = {1'b0, acc} + {1'b0, opnd_r};
        n_acc = ext[DW-1:0];
        n_cy  = ext[DW];
      end
      OP_SUB: begin
        ext   = {1'b0, acc} - {1'b0, opnd_r};
        n_acc = ext[DW-1:0];
        n_cy  = ext[DW];
      end
      OP_ANA: begin n_acc = acc & opnd_r; n_cy = 1'b0; end
      OP_XRA: begin n_acc = acc ^ opnd_r; n_cy = 1'b0; end
      OP_LDA:   n_acc = opnd_m;
      OP_STA:   n_dm_we = 1'b1;
      OP_INR:   n_acc = acc + 1'b1;
      OP_JMP:   take = 1'b1;
      OP_JZ:    take = z;
      OP_JC:    take = cy;
      OP_ADI: begin
        ext   = {1'b0, acc} + {1'b0, f};
        n_acc = ext[DW-1:0];
        n_cy  = ext[DW];
      end
      OP_HLT:   hlt = 1'b1;
      default:  ;
    endcase
    if (op inside {OP_ADD, OP_SUB, OP_ANA, OP_XRA, OP_INR, OP_ADI})
      n_z = (n_acc == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      acc      <= '0;
      cy       <= 1'b0;
      z        <= 1'b0;
      halted   <= 1'b0;
      if_ir    <= NOP;
      wb_rf_we <= 1'b0;
      wb_dm_we <= 1'b0;
      wb_ridx  <= '0;
      wb_midx  <= '0;
      wb_data  <= '0;
    end else if (run) begin
      // WB drains every running cycle; a stall or halt feeds it a bubble.
      if (halted || stall) begin
        wb_rf_we <= 1'b0;
        wb_dm_we <= 1'b0;
      end else begin
        acc      <= n_acc;
        cy       <= n_cy;
        z        <= n_z;
        wb_rf_we <= n_rf_we;
        wb_dm_we <= n_dm_we;
        wb_ridx  <= ridx;
        wb_midx  <= midx;
        wb_data  <= acc;
        if (hlt) begin
          halted <= 1'b1;
          if_ir  <= NOP;
        end else if (take) begin
          pc    <= jtgt;
          if_ir <= NOP;
        end else begin
          if_ir <= imem[pc];
          pc    <= (pc == PW'(IM_DEPTH - 1)) ? '0 : pc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (run && wb_rf_we) begin
      rf[wb_ridx] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && run && wb_dm_we) dm[wb_midx] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_addr] <= imem_wdata;
  end
endmodule

// File: tb/tb_pipe_accum_core.sv
// tb/tb_pipe_accum_core.sv - directed vector bench for pipe_accum_core (default parameters).
module tb_pipe_accum_core;
  logic        clk = 1'b0;
  logic        rst, run, imem_we;
  logic [5:0]  imem_addr;
  logic [11:0] imem_wdata;
  logic [7:0]  dbg_sel;
  logic [7:0]  dbg_reg, dbg_dm, acc;
  logic [5:0]  pc;
  logic        cy, z, halted;

  pipe_accum_core dut (
    .clk(clk), .rst(rst), .run(run), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .dbg_sel(dbg_sel), .dbg_reg(dbg_reg), .dbg_dm(dbg_dm),
    .pc(pc), .acc(acc), .cy(cy), .z(z), .halted(halted)
  );

  always #5 clk = ~clk;

`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] acc;
    logic       cy;
    logic       z;
    logic [5:0] pc;
    logic [7:0] cyc_f;
    logic [7:0] cyc_n;
    logic [7:0] dsel;
    logic [7:0] dreg;
    logic       chk_dm;
    logic [7:0] ddm;
  } vec_t;

  logic [11:0] progs [11][16];
  vec_t        vecs  [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ncyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_prog(input int s, input logic [12*12-1:0] words, input int n);
    for (int i = 0; i < n; i++) progs[s][i] = words[(n-1-i)*12 +: 12];
  endtask

  task automatic load_prog(input int s);
    run = 1'b0;
    imem_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      imem_addr = 6'(i);
      imem_wdata = progs[s][i];
      @(posedge clk); #1;
    end
    imem_we = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_to_halt(output int n);
    run = 1'b1;
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (halted) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run = 1'b0; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0; dbg_sel = '0;
    for (int s = 0; s < 11; s++)
      for (int i = 0; i < 16; i++) progs[s][i] = 12'hF00;
    add_prog(0, {12'h105, 12'hEFC, 12'hF00}, 3);
    add_prog(1, {12'h12A, 12'h304, 12'h100, 12'h404, 12'hF00}, 5);
    add_prog(2, {12'h12A, 12'h304, 12'h404, 12'hF00}, 4);
    add_prog(3, {12'h133, 12'h940, 12'h840, 12'h941, 12'hF00}, 5);
    add_prog(4, {12'h101, 12'h500, 12'h100, 12'h700, 12'hC06, 12'h177, 12'hF00}, 7);
    add_prog(5, {12'h1FF, 12'hE01, 12'hD04, 12'h1AA, 12'hA00, 12'h30A, 12'hB08,
                 12'h1BB, 12'h10F, 12'h60A, 12'hF00}, 11);
    add_prog(6, {12'h105, 12'hE00, 12'hC05, 12'hD05, 12'h110, 12'h301, 12'h108,
                 12'h501, 12'hF00}, 9);
    add_prog(7, {12'h1C3, 12'h3FB, 12'h703, 12'h15A, 12'h9C5, 12'h845, 12'hF00}, 7);
    add_prog(8, {12'h111, 12'h950, 12'hF00}, 3);
    add_prog(9, {12'h15A, 12'h950, 12'hF00}, 3);
    add_prog(10, {12'h133, 12'h942, 12'h842, 12'hE01, 12'h943, 12'hF00}, 6);
    //             acc    cy    z     pc    cyc_f cyc_n dsel   dreg   chk   ddm
    vecs[0] = '{8'h01, 1'b1, 1'b0, 6'd3,  8'd4,  8'd4,  8'h00, 8'h00, 1'b0, 8'h00};
    vecs[1] = '{8'h2A, 1'b0, 1'b0, 6'd5,  8'd6,  8'd6,  8'h04, 8'h2A, 1'b0, 8'h00};
    vecs[2] = '{8'h54, 1'b0, 1'b0, 6'd4,  8'd5,  8'd6,  8'h04, 8'h2A, 1'b0, 8'h00};
    vecs[3] = '{8'h33, 1'b0, 1'b0, 6'd5,  8'd6,  8'd7,  8'h41, 8'h00, 1'b1, 8'h33};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 6'd7,  8'd8,  8'd8,  8'h00, 8'h00, 1'b0, 8'h00};
    vecs[5] = '{8'h01, 1'b0, 1'b0, 6'd11, 8'd12, 8'd12, 8'h0A, 8'h01, 1'b0, 8'h00};
    vecs[6] = '{8'hF8, 1'b1, 1'b0, 6'd9,  8'd10, 8'd10, 8'h01, 8'h10, 1'b0, 8'h00};
    vecs[7] = '{8'h5A, 1'b0, 1'b1, 6'd7,  8'd8,  8'd10, 8'hC5, 8'h00, 1'b1, 8'h5A};

    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset pc", 32'(pc), 0);
    chk("reset acc", 32'(acc), 0);
    chk("reset flags", {30'd0, cy, z}, 0);
    chk("reset halted", 32'(halted), 0);
    dbg_sel = 8'h03;
    #1 chk("reset reg3", 32'(dbg_reg), 0);

    for (int v = 0; v < 8; v++) begin
      load_prog(v);
      reset_dut();
      run_to_halt(ncyc);
      chk($sformatf("v%0d cycles", v), 32'(ncyc), 32'(FWD ? vecs[v].cyc_f : vecs[v].cyc_n));
      chk($sformatf("v%0d halted", v), 32'(halted), 1);
      repeat (2) begin @(posedge clk); #1; end
      chk($sformatf("v%0d pc", v), 32'(pc), 32'(vecs[v].pc));
      chk($sformatf("v%0d acc", v), 32'(acc), 32'(vecs[v].acc));
      chk($sformatf("v%0d cy", v), 32'(cy), 32'(vecs[v].cy));
      chk($sformatf("v%0d z", v), 32'(z), 32'(vecs[v].z));
      dbg_sel = vecs[v].dsel;
      #1 chk($sformatf("v%0d dbg_reg", v), 32'(dbg_reg), 32'(vecs[v].dreg));
      if (vecs[v].chk_dm) chk($sformatf("v%0d dbg_dm", v), 32'(dbg_dm), 32'(vecs[v].ddm));
      run = 1'b0;
    end

    // Reset lands while STA 50 is waiting in WB: the store must be lost.
    load_prog(8);
    reset_dut();
    run_to_halt(ncyc);
    dbg_sel = 8'h50;
    #1 chk("rstmid seed dm50", 32'(dbg_dm), 32'h11);
    load_prog(9);
    reset_dut();
    run = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid pc", 32'(pc), 0);
    chk("rstmid acc", 32'(acc), 0);
    chk("rstmid flags", {30'd0, cy, z}, 0);
    chk("rstmid halted", 32'(halted), 0);
    chk("rstmid dm50 kept", 32'(dbg_dm), 32'h11);
    run_to_halt(ncyc);
    chk("rstmid rerun cycles", 32'(ncyc), 4);
    chk("rstmid rerun acc", 32'(acc), 32'h5A);
    chk("rstmid rerun dm50", 32'(dbg_dm), 32'h5A);
    run = 1'b0;

    // Pause three cycles with a store pending in WB.
    load_prog(10);
    reset_dut();
    run = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("pause entry pc", 32'(pc), 3);
    chk("pause entry acc", 32'(acc), 32'h33);
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("pause%0d pc", k), 32'(pc), 3);
      chk($sformatf("pause%0d acc", k), 32'(acc), 32'h33);
      chk($sformatf("pause%0d halted", k), 32'(halted), 0);
    end
    run_to_halt(ncyc);
    chk("pause resume cycles", 32'(ncyc), FWD ? 4 : 5);
    chk("pause acc", 32'(acc), 32'h34);
    chk("pause flags", {30'd0, cy, z}, 0);
    dbg_sel = 8'h42;
    #1 chk("pause dm42", 32'(dbg_dm), 32'h33);
    dbg_sel = 8'h43;
    #1 chk("pause dm43", 32'(dbg_dm), 32'h34);
    run = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
